booth_mul_arbiter: RTL and testbench
====================================

BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 Parameter MUL_CYCLES, default 4: Booth iteration count at which the multiplier reports completion (mul_count == MUL_CYCLES).
REQ-002 Parameter TIMEOUT, default 12: maximum RUN-state cycles before the operation is aborted.
REQ-003 clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0/req1  input  1 each  requester 0/1 multiply request; held high until that requester's done pulse.
REQ-006 a0/b0, a1/b1  input  4 each  requester operands (multiplicand/multiplier, two's complement); stable while req is high.
REQ-007 done0/done1  output  1 each  one-cycle completion pulse to the owning requester.
REQ-008 result0/result1  output  8 each  signed product; holds its last value until that requester's next done.
REQ-009 err  output  1  valid with done; 1 = operation aborted by timeout.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 owner  output  1  index of the granted requester; holds its value in IDLE.
REQ-012 mul_in1/mul_in2  output  4 each  operands driven to the shared Booth multiplier.
REQ-013 mul_start_n  output  1  active-low load strobe to the multiplier.
REQ-014 mul_count  input  3  multiplier iteration counter.
REQ-015 mul_result  input  8  multiplier product {A,Q}.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, LOAD, RUN and DONE.
REQ-017 IDLE SHALL go to LOAD when any req is high, latching the winner's operands into internal registers and setting owner.
REQ-018 Arbitration SHALL be round-robin: with both reqs high, the requester not served last wins; after reset requester 0 wins the first tie.
REQ-019 LOAD SHALL last exactly one cycle, drive mul_start_n = 0, and go to RUN.
REQ-020 In all states except LOAD, mul_start_n SHALL be 1.
REQ-021 mul_start_n SHALL be decoded from registered state only, with no combinational path from req.
REQ-022 mul_in1/mul_in2 SHALL present the latched operands from LOAD through DONE inclusive; operand changes on inputs after the grant SHALL be ignored.
REQ-023 RUN SHALL go to DONE when mul_count == MUL_CYCLES, capturing mul_result into the owner's result register and setting err = 0.
REQ-024 RUN SHALL also go to DONE with err = 1 once TIMEOUT RUN cycles elapse without completion; the owner's result register is then unchanged.
REQ-025 DONE SHALL last one cycle, pulse the owner's done (if its req is still high), update the round-robin pointer, and return to IDLE.
REQ-026 Latency: the owner's done SHALL be high MUL_CYCLES+2 rising edges after the IDLE edge that sampled the req (6 with defaults).
REQ-027 If the owner drops req before DONE, the operation SHALL still complete, with its done pulse and result update suppressed; the pointer still advances.
REQ-028 A req arriving while busy SHALL wait, with no loss; the next grant occurs in the IDLE cycle following DONE.
REQ-029 done0 and done1 SHALL never be high in the same cycle.

Reset
REQ-030 While reset = 0, the block SHALL asynchronously force: state = IDLE, done0 = done1 = 0, err = 0, busy = 0, owner = 0, result0 = result1 = 0, latched operands = 0, mul_start_n = 1, timeout counter = 0, pointer = "requester 1 served last".
REQ-031 Reset asserted mid-operation SHALL abandon the operation, with no done pulse after release.
REQ-032 The first grant after reset release SHALL follow REQ-017/018.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, MUL_CYCLES and TIMEOUT defaults, and the operand/product width constants (4/8).
REQ-034 The arbiter SHALL contain no arithmetic on the product and SHALL instantiate no multiplier.
REQ-035 The round-robin selector SHALL be one sub-module named rr_pick2, inputs req0, req1 and last, output grant index plus valid.

Verification
REQ-036 req0 with a0 = 3, b0 = 2 -> mul_start_n low one cycle; done0 at edge 6; result0 = 8'h06; err = 0.
REQ-037 req1 with a1 = -3 (4'hD), b1 = 5 -> result1 = 8'hF1 (-15); done0 never asserts.
REQ-038 req0 and req1 raised on the same cycle, both held, three operations each -> grants alternate 0,1,0,1,0,1; no two dones in the same cycle.
REQ-039 Multiplier model that freezes mul_count at 2 -> done pulses after TIMEOUT RUN cycles with err = 1; result unchanged.
REQ-040 reset pulsed low during RUN -> all outputs at their reset values immediately; no done after release; the next req is served normally.
REQ-041 req0 dropped during RUN -> no done0, result0 unchanged; a pending req1 is granted in the next IDLE cycle.

Source files
------------

// File: rtl/booth_mul_arbiter_pkg.sv
// booth_mul_arbiter_pkg: shared widths, timing defaults and FSM encoding for the Booth multiplier arbiter
package booth_mul_arbiter_pkg;
    localparam int OP_W           = 4;
    localparam int PROD_W         = 8;
    localparam int CNT_W          = 3;
    localparam int MUL_CYCLES_DEF = 4;
    localparam int TIMEOUT_DEF    = 12;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/booth_mul_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the requester not served last wins
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant,
    output logic valid
);
    assign valid = req0 | req1;
    assign grant = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: shares one external Booth multiplier between two requesters with round-robin and timeout
module booth_mul_arbiter
    import booth_mul_arbiter_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [OP_W-1:0]   a0,
    input  logic [OP_W-1:0]   b0,
    input  logic [OP_W-1:0]   a1,
    input  logic [OP_W-1:0]   b1,
    output logic              done0,
    output logic              done1,
    output logic [PROD_W-1:0] result0,
    output logic [PROD_W-1:0] result1,
    output logic              err,
    output logic              busy,
    output logic              owner,
    output logic [OP_W-1:0]   mul_in1,
    output logic [OP_W-1:0]   mul_in2,
    output logic              mul_start_n,
    input  logic [CNT_W-1:0]  mul_count,
    input  logic [PROD_W-1:0] mul_result
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [PROD_W-1:0] res0_q, res0_d, res1_q, res1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              err_q, err_d;
    logic              pick_grant, pick_valid;
    logic              mul_fin, tmo_hit, own_req;

    rr_pick2 u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (last_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    assign mul_fin = mul_count == CNT_W'(MUL_CYCLES);
    assign tmo_hit = tmo_q == TW'(TIMEOUT - 1);
    assign own_req = owner_q ? req1 : req0;

    // Next-state: grant and latch in IDLE, strobe in LOAD, wait/timeout in RUN, advance pointer in DONE
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        tmo_d   = tmo_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = LOAD;
                    owner_d = pick_grant;
                    a_d     = pick_grant ? a1 : a0;
                    b_d     = pick_grant ? b1 : b0;
                end
            end
            LOAD: begin
                state_d = RUN;
                tmo_d   = '0;
            end
            RUN: begin
                tmo_d = tmo_q + TW'(1);
                if (mul_fin || tmo_hit) begin
                    state_d = DONE;
                    tmo_d   = '0;
                    err_d   = !mul_fin;
                    done0_d = own_req && !owner_q;
                    done1_d = own_req && owner_q;
                    if (mul_fin && own_req && !owner_q) res0_d = mul_result;
                    if (mul_fin && own_req && owner_q) res1_d = mul_result;
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = owner_q;
            end
        endcase
    end

    // State registers with asynchronous active-low reset; pointer resets to "requester 1 served last"
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            tmo_q   <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tmo_q   <= tmo_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err_q   <= err_d;
        end
    end

    assign done0       = done0_q;
    assign done1       = done1_q;
    assign result0     = res0_q;
    assign result1     = res1_q;
    assign err         = err_q;
    assign owner       = owner_q;
    assign busy        = state_q != IDLE;
    assign mul_start_n = state_q != LOAD;
    assign mul_in1     = a_q;
    assign mul_in2     = b_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: randomized self-checking bench with a behavioural multiplier and arbitration model
module tb_booth_mul_arbiter;
    localparam int MC = 4;
    localparam int TO = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic       done0, done1, err, busy, owner, mul_start_n;
    logic [7:0] result0, result1;
    logic [3:0] mul_in1, mul_in2;
    logic [2:0] mul_count = 3'd0;
    logic [7:0] mul_result;
    logic [7:0] prod = 8'd0;
    logic       freeze;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] exp_res [2];
    logic [3:0] oa [2];
    logic [3:0] ob [2];
    int         rem [2];
    int         expt, last_cyc, w;
    bit         first;
    logic [7:0] e;

    booth_mul_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .a0          (a0),
        .b0          (b0),
        .a1          (a1),
        .b1          (b1),
        .done0       (done0),
        .done1       (done1),
        .result0     (result0),
        .result1     (result1),
        .err         (err),
        .busy        (busy),
        .owner       (owner),
        .mul_in1     (mul_in1),
        .mul_in2     (mul_in2),
        .mul_start_n (mul_start_n),
        .mul_count   (mul_count),
        .mul_result  (mul_result)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] smul(input logic [3:0] x, input logic [3:0] y);
        int xi, yi;
        xi = int'($signed(x));
        yi = int'($signed(y));
        return 8'(xi * yi);
    endfunction

    // Behavioural Booth multiplier: restarts on the load strobe, counts to MC, optionally stalls at 2
    always @(posedge clk) begin
        if (!mul_start_n) begin
            mul_count <= 3'd0;
            prod      <= smul(mul_in1, mul_in2);
        end else if (mul_count != 3'(MC) && !(freeze && mul_count == 3'd2)) begin
            mul_count <= mul_count + 3'd1;
        end
    end
    assign mul_result = (mul_count == 3'(MC)) ? prod : 8'hA5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input int r);
        return r != 0 ? done1 : done0;
    endfunction

    function automatic logic [7:0] res_of(input int r);
        return r != 0 ? result1 : result0;
    endfunction

    task automatic set_req(input int r, input logic v);
        if (r != 0) req1 = v;
        else req0 = v;
    endtask

    task automatic set_ops(input int r, input logic [3:0] a, input logic [3:0] b);
        if (r != 0) begin a1 = a; b1 = b; end
        else begin a0 = a; b0 = b; end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_done0"}, done0, 0);
        check({tag, "_done1"}, done1, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_owner"}, owner, 0);
        check({tag, "_result0"}, result0, 0);
        check({tag, "_result1"}, result1, 0);
        check({tag, "_start_n"}, mul_start_n, 1);
        check({tag, "_mul_in1"}, mul_in1, 0);
        check({tag, "_mul_in2"}, mul_in2, 0);
    endtask

    task automatic run_single(input int r, input logic [3:0] a, input logic [3:0] b, input bit scr);
        logic [7:0] ex;
        ex = smul(a, b);
        @(negedge clk);
        set_ops(r, a, b);
        set_req(r, 1'b1);
        for (int k = 0; k <= 8; k++) begin
            tick();
            check("done_own", done_of(r), k == 6);
            check("done_other", done_of(1 - r), 0);
            check("start_n", mul_start_n, k != 0);
            if (k == 0) begin
                check("owner", owner, r);
                check("busy", busy, 1);
            end
            if (k == 1 && scr) set_ops(r, 4'($urandom), 4'($urandom));
            if (k == 3) begin
                check("mul_in1", mul_in1, a);
                check("mul_in2", mul_in2, b);
            end
            if (k == 6) begin
                check("result", res_of(r), ex);
                check("err", err, 0);
                check("result_other", res_of(1 - r), exp_res[1 - r]);
                exp_res[r] = ex;
                set_req(r, 1'b0);
            end
            if (k >= 7) check("busy_idle", busy, 0);
        end
    endtask

    initial begin
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0; freeze = 1'b0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        exp_res[0] = 8'd0; exp_res[1] = 8'd0;
        repeat (2) @(negedge clk);
        check_reset("por");
        reset = 1'b1;
        run_single(0, 4'd3, 4'd2, 1'b0);
        check("res0_const", result0, 8'h06);
        run_single(1, 4'hD, 4'd5, 1'b0);
        check("res1_const", result1, 8'hF1);
        repeat (8) run_single(int'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'b1);
        freeze = 1'b1;
        @(negedge clk);
        set_ops(0, 4'($urandom), 4'($urandom));
        req0 = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            tick();
            check("to_done", done0, k == TO + 1);
            check("to_err", err, k == TO + 1);
            if (k == TO + 1) begin
                check("to_result", result0, exp_res[0]);
                req0 = 1'b0;
            end
        end
        freeze = 1'b0;
        @(negedge clk);
        set_ops(0, 4'($urandom), 4'($urandom));
        req0 = 1'b1;
        oa[1] = 4'($urandom); ob[1] = 4'($urandom);
        for (int k = 0; k <= 16; k++) begin
            tick();
            if (k == 2) begin
                set_ops(1, oa[1], ob[1]);
                req1 = 1'b1;
            end
            if (k == 3) req0 = 1'b0;
            check("drop_done0", done0, 0);
            check("drop_done1", done1, k == 14);
            if (k == 8) begin
                check("drop_owner", owner, 1);
                check("drop_start_n", mul_start_n, 0);
            end
            if (k == 14) begin
                check("drop_result1", result1, smul(oa[1], ob[1]));
                check("drop_result0", result0, exp_res[0]);
                exp_res[1] = smul(oa[1], ob[1]);
                req1 = 1'b0;
            end
        end
        @(negedge clk);
        set_ops(1, 4'($urandom), 4'($urandom));
        req1 = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        check_reset("mid");
        req1 = 1'b0;
        exp_res[0] = 8'd0; exp_res[1] = 8'd0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("post_rst_done", done0 | done1, 0);
            check("post_rst_busy", busy, 0);
        end
        rem[0] = 3; rem[1] = 3; expt = 0; last_cyc = 0; first = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            oa[r] = 4'($urandom); ob[r] = 4'($urandom);
            set_ops(r, oa[r], ob[r]);
        end
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 0; c < 200 && (rem[0] > 0 || rem[1] > 0); c++) begin
            tick();
            check("dual_done", done0 & done1, 0);
            if (done0 | done1) begin
                w = done1 ? 1 : 0;
                check("turn", w, expt);
                check("gap", c - last_cyc, first ? 6 : 8);
                e = smul(oa[w], ob[w]);
                check("result_rr", res_of(w), e);
                check("err_rr", err, 0);
                first = 1'b0;
                last_cyc = c;
                rem[w]--;
                expt = rem[1 - w] > 0 ? 1 - w : w;
                if (rem[w] == 0) set_req(w, 1'b0);
                else begin
                    oa[w] = 4'($urandom); ob[w] = 4'($urandom);
                    set_ops(w, oa[w], ob[w]);
                end
            end
        end
        check("rr_all_done", rem[0] + rem[1], 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
